uart_rx: RTL and testbench

//   Receives one asynchronous UART frame (1 start, DATA_WIDTH data bits LSB first, 1 stop, no parity)

---
 rtl/uart_rx.sv | 109 ++++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 1 start, DATA_WIDTH data bits LSB first, 1 stop.
// Ports: clk, rst (sync high), rx_i serial in, rx_ready_o idle flag,
//   data_o last good word, data_valid_o / frame_err_o 1-cycle strobes.
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_i,
  output logic                  rx_ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  output logic                  frame_err_o
);

  localparam int BAUD_CNT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CNT = BAUD_CNT / 2;
  localparam int CW = $clog2(BAUD_CNT);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic [2:0]            state;
  logic [1:0]            sync;
  logic                  rx_sync;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         lim;
  logic                  tick;
  logic [BW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;

  assign rx_sync    = sync[1];
  assign rx_ready_o = (state == S_IDLE);

  // START waits half a bit so later ticks land mid-bit
  assign lim  = (state == S_START) ? CW'(HALF_CNT - 1)
                                   : CW'(BAUD_CNT - 1);
  assign tick = (cnt == lim);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      sync         <= 2'b11;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      sync         <= {sync[0], rx_i};
      data_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      cnt          <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_sync) state <= S_START;
        end
        S_START: begin
          if (tick) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (tick) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[DATA_WIDTH-1:1]};
            if (bit_idx == BW'(DATA_WIDTH - 1))
              state <= S_STOP;
            else
              bit_idx <= bit_idx + 1'b1;
          end
        end
        S_STOP: begin
          if (tick) begin
            cnt <= '0;
            if (rx_sync) begin
              data_o       <= shreg;
              data_valid_o <= 1'b1;
              state        <= S_IDLE;
            end else begin
              frame_err_o <= 1'b1;
              state       <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          // a held-low line must go high before a new start
          cnt <= '0;
          if (rx_sync) state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized + directed frames, scoreboard monitor.
// Expected strobes queued at stimulus time, popped on DUT strobe.
module tb_uart_rx;

  localparam int CLK_FREQ = 16;
  localparam int BAUD_RATE = 1;
  localparam int DW = 8;
  localparam int BAUD = CLK_FREQ / BAUD_RATE;
  localparam int HALF = BAUD / 2;
  // edges after edge 0 until the stop-bit decision cycle
  localparam int LAT = HALF + 1 + (DW + 1) * BAUD;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic       rx_ready_o;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       frame_err_o;

  exp_t       sbq[$];
  logic [7:0] model_data = 8'h00;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_i(rx_i),
    .rx_ready_o(rx_ready_o),
    .data_o(data_o),
    .data_valid_o(data_valid_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // abort_bit >= 0 stops driving before that data bit
  task automatic send(input logic [7:0] d, input bit stop,
                      input int abort_bit);
    exp_t e;
    if (abort_bit < 0) begin
      e.is_err = !stop;
      e.t0 = cyc;
      if (stop) model_data = d;
      e.data = model_data;
      sbq.push_back(e);
    end
    rx_i = 1'b0;
    step(BAUD);
    for (int i = 0; i < DW; i++) begin
      if (i == abort_bit) return;
      rx_i = d[i];
      step(BAUD);
    end
    rx_i = stop;
    step(BAUD);
  endtask

  initial begin : monitor
    exp_t e;
    bit   prev;
    bit   ok;
    int   want;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (data_valid_o || frame_err_o) begin
          n_tests++;
          if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_strobe: valid=%0b err=%0b data=%0h cyc=%0d",
                     data_valid_o, frame_err_o, data_o, cyc);
          end else begin
            e = sbq.pop_front();
            want = e.t0 + 1 + LAT;
            ok = (frame_err_o == e.is_err) &&
                 (data_valid_o == !e.is_err) &&
                 (data_o == e.data) &&
                 (cyc == want || cyc == want + 1) &&
                 !prev;
            if (!ok) begin
              n_fail++;
              $display("FAIL strobe: valid=%0b err=%0b data=%0h cyc=%0d prev=%0b; expected err=%0b data=%0h cyc=%0d..%0d",
                       data_valid_o, frame_err_o, data_o, cyc, prev,
                       e.is_err, e.data, want, want + 1);
            end
          end
        end
        prev = data_valid_o || frame_err_o;
      end
    end
  end

  initial begin : stim
    int c;
    logic [7:0] d;
    bit stop;

    rst = 1'b1;
    rx_i = 1'b1;
    step(3);
    chk("rst_data", data_o, 0);
    chk("rst_valid", data_valid_o, 0);
    chk("rst_err", frame_err_o, 0);
    chk("rst_ready", rx_ready_o, 1);
    rst = 1'b0;
    step(2);

    c = cyc;
    fork
      send(8'hA5, 1'b1, -1);
      begin
        step(2);
        chk("ready_before_start", rx_ready_o, 1);
        step(1);
        chk("ready_in_start", rx_ready_o, 0);
        step(150);
        chk("ready_late_frame", rx_ready_o, 0);
      end
    join
    chk("ready_after_a5", rx_ready_o, 1);
    chk("data_a5", data_o, 8'hA5);
    step(5);

    rx_i = 1'b0;
    step(3);
    chk("glitch_start", rx_ready_o, 0);
    step(1);
    rx_i = 1'b1;
    step(30);
    chk("glitch_ready", rx_ready_o, 1);
    chk("glitch_data", data_o, model_data);

    send(8'h3C, 1'b0, -1);
    step(40);
    chk("break_ready", rx_ready_o, 0);
    chk("break_data", data_o, 8'hA5);
    rx_i = 1'b1;
    step(5);
    chk("break_exit", rx_ready_o, 1);
    step(10);

    send(8'h00, 1'b1, -1);
    send(8'hFF, 1'b1, -1);
    step(10);
    chk("b2b_data", data_o, 8'hFF);

    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send(d, stop, -1);
      if (!stop) begin
        step($urandom_range(0, 10));
        rx_i = 1'b1;
        step($urandom_range(3, 20));
      end else begin
        step($urandom_range(0, 20));
      end
    end
    step(10);
    chk("rand_data", data_o, model_data);

    send(8'h77, 1'b1, 4);
    rx_i = 1'b1;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    model_data = 8'h00;
    chk("midrst_data", data_o, model_data);
    chk("midrst_ready", rx_ready_o, 1);
    step(20);
    send(8'h5A, 1'b1, -1);
    step(10);
    chk("data_5a", data_o, 8'h5A);

    step(200);
    chk("queue_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
